ex_muldiv: RTL
==============

// Module: ex_muldiv
// PURPOSE
//  Iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the
//  ex stage. ex starts it for an M-class aluop. While busy it holds stall_req_o to
//  freeze IF/ID/EX. It returns the result and destination register to ex for writeback
//  through wdata_o/wd_o. Width and per-cycle radix are parametrised.
// PARAMETERS
//  XLEN       32  operand/result width; must be even and >= 8
//  BITS_PER   1   bits retired per CALC cycle (1 or 2); XLEN % BITS_PER == 0
// PORTS
//  clk        in   1     clock
//  rst        in   1     synchronous reset, active-low (rst==0 resets on clk rising edge)
//  start_i    in   1     request; sampled only in IDLE
//  op_i       in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  reg1_i     in   XLEN  rs1 operand (dividend / multiplicand)
//  reg2_i     in   XLEN  rs2 operand (divisor / multiplier)
//  wd_i       in   5     destination register address
//  flush_i    in   1     abort in-flight op (branch taken in EX)
//  stall_req_o out 1     pipeline stall request
//  done_o     out  1     one-cycle pulse: wdata_o/wd_o valid
//  wdata_o    out  XLEN  result
//  wd_o       out  5     destination register, latched at start
// BEHAVIOUR
//  Reset (rst==0): state=IDLE; stall_req_o=0, done_o=0, wdata_o=0, wd_o=0; internal regs cleared.
//  FSM IDLE -> CALC -> DONE -> IDLE. N = XLEN/BITS_PER.
//  IDLE: start_i=1 & flush_i=0 -> latch op, |operands| + sign flags, wd_i -> CALC (count=N).
//   stall_req_o is combinationally 1 in that same cycle so ex holds the instruction.
//  CALC: retire BITS_PER bits/cycle. Multiply is shift-add on the 2*XLEN product.
//   Divide is restoring, unsigned on magnitudes. After N cycles -> DONE. stall_req_o=1 throughout.
//  DONE: done_o=1 and stall_req_o=0 for exactly one cycle.
//   wdata_o = sign-fixed result; wd_o = latched dest. Then -> IDLE.
//  wdata_o/wd_o hold their value after DONE until the next DONE.
//  Latency: start in cycle 0, done_o in cycle N+1. XLEN=32, BITS_PER=1 -> cycle 33.
//  Result select: MUL = product[XLEN-1:0]; MULH/MULHSU/MULHU = product[2XLEN-1:XLEN].
//   MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
//   Product is negated when exactly one signed operand is negative.
//  DIV: quotient truncated toward zero, negated if the operand signs differ.
//  REM: remainder takes the dividend's sign.
//  Special cases skip CALC (IDLE -> DONE, done in cycle 1):
//   divisor==0: DIV/DIVU -> all ones; REM/REMU -> reg1_i.
//   signed overflow (reg1=-2^(XLEN-1), reg2=-1): DIV -> reg1_i; REM -> 0.
//  flush_i=1 in CALC or DONE: -> IDLE next cycle. done_o is forced 0 that cycle.
//   stall_req_o=0; wdata_o/wd_o unchanged.
//  flush_i=1 in IDLE: start_i is ignored.
//  start_i outside IDLE is ignored; ex must not issue a new op while stall_req_o=1.
//  rst==0 mid-operation: reset wins over everything; the op is discarded.
//  wd_i==0 is computed normally; write suppression for x0 stays in ex.
// TESTING
//  MUL 7 x -3 (XLEN=32) -> done_o at cycle 33, wdata_o=0xFFFFFFEB, stall_req_o high cycles 0-32.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> wdata_o=0xFFFFFFFE; MULH same -> 0x00000000;
//   MULHSU -1 x 2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV x/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  Start DIV, flush_i at cycle 10 -> IDLE at 11, no done_o, stall_req_o=0.
//   A new MUL 3x4 right after -> 12 with wd_o of the new op.
//  rst=0 at cycle 5 of a DIV -> all outputs 0 next edge. Repeat with BITS_PER=2, XLEN=16:
//   MUL 300x300 -> 0x5F90, done at cycle 9.

Source files
------------

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv -- iterative RV M-extension unit sitting beside the ex stage.
//
// Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on operand magnitudes.
// Multiply is a shift-add over a 2*XLEN accumulator. Divide is restoring
// division over the same accumulator. Signs are fixed up when the result is
// delivered. BITS_PER bits are retired per CALC cycle.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active low
//   start_i      request, sampled only while idle
//   op_i         funct3 (0 MUL .. 7 REMU)
//   reg1_i       rs1 operand (multiplicand / dividend)
//   reg2_i       rs2 operand (multiplier / divisor)
//   wd_i         destination register, latched at start
//   flush_i      abort the in-flight operation
//   stall_req_o  holds IF/ID/EX while an operation is accepted or computing
//   done_o       one-cycle pulse; wdata_o/wd_o are valid in that cycle
//   wdata_o      result, held until the next done_o
//   wd_o         destination register, held until the next done_o
// ---------------------------------------------------------------------------
module ex_muldiv #(
   parameter int XLEN     = 32,
   parameter int BITS_PER = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] reg1_i,
   input  logic [XLEN-1:0] reg2_i,
   input  logic [4:0]      wd_i,
   input  logic            flush_i,
   output logic            stall_req_o,
   output logic            done_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [4:0]      wd_o
);

   localparam int N  = XLEN / BITS_PER;
   localparam int CW = $clog2(N + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        op_reg;
   logic [4:0]        wd_reg;
   logic [XLEN-1:0]   opnd_reg;      // multiplicand magnitude or divisor magnitude
   logic [2*XLEN-1:0] acc_reg;       // {product} or {remainder, quotient}
   logic              neg_q_reg;     // negate product / quotient
   logic              neg_r_reg;     // negate remainder
   logic [CW-1:0]     count_reg;
   logic [XLEN-1:0]   wdata_reg;
   logic [4:0]        wd_out_reg;

   // ---------------- start-time operand decode ----------------
   logic            rs1_signed, rs2_signed, neg_a, neg_b;
   logic            div_zero, div_ovf, accept;
   logic [XLEN-1:0] a_mag, b_mag;

   always_comb begin
      rs1_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
      rs2_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
      neg_a      = rs1_signed & reg1_i[XLEN-1];
      neg_b      = rs2_signed & reg2_i[XLEN-1];
      // -MIN_NEG wraps to itself, which is the correct unsigned magnitude
      a_mag      = neg_a ? (~reg1_i + 1'b1) : reg1_i;
      b_mag      = neg_b ? (~reg2_i + 1'b1) : reg2_i;
      div_zero   = op_i[2] & (reg2_i == '0);
      div_ovf    = op_i[2] & ~op_i[0] & (reg1_i == MIN_NEG) & (reg2_i == '1);
   end

   assign accept = (state_reg == IDLE) & start_i & ~flush_i;

   // ---------------- one iteration of the datapath ----------------
   function automatic logic [2*XLEN-1:0] step_fn(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   opnd,
                                                 input logic              is_div);
      logic [XLEN:0]   mul_sum;
      logic [XLEN:0]   rem_ext;
      logic            fits;
      logic [XLEN-1:0] rem_new;
      // multiply: add multiplicand into the high half when the current
      // multiplier bit (acc[0]) is set, then shift the whole thing right
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      // divide: shift next dividend bit into the remainder, subtract if it fits.
      // The difference is always < divisor so XLEN-bit modular subtraction is exact.
      rem_ext = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      fits    = rem_ext >= {1'b0, opnd};
      rem_new = fits ? (rem_ext[XLEN-1:0] - opnd) : rem_ext[XLEN-1:0];
      return is_div ? {rem_new, acc[XLEN-2:0], fits} : {mul_sum, acc[XLEN-1:1]};
   endfunction

   logic [2*XLEN-1:0] acc_step;

   always_comb begin
      acc_step = acc_reg;
      for (int i = 0; i < BITS_PER; i++) begin
         acc_step = step_fn(acc_step, opnd_reg, op_reg[2]);
      end
   end

   // ---------------- sign fix-up and result select ----------------
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, result;

   always_comb begin
      prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
      quot_fix = neg_q_reg ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];
      rem_fix  = neg_r_reg ? (~acc_reg[2*XLEN-1:XLEN] + 1'b1) : acc_reg[2*XLEN-1:XLEN];
      if (!op_reg[2]) begin
         result = (op_reg[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      end else begin
         result = op_reg[1] ? rem_fix : quot_fix;
      end
   end

   // ---------------- FSM next state / outputs ----------------
   always_comb begin
      state_next  = state_reg;
      stall_req_o = 1'b0;
      done_o      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               stall_req_o = 1'b1;
               state_next  = (div_zero | div_ovf) ? DONE : CALC;
            end
         end
         CALC: begin
            if (flush_i) begin
               state_next = IDLE;
            end else begin
               stall_req_o = 1'b1;
               if (count_reg == CW'(1)) state_next = DONE;
            end
         end
         DONE: begin
            done_o     = ~flush_i;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Result is shown directly in the done cycle; registered copies hold it afterwards.
   assign wdata_o = done_o ? result : wdata_reg;
   assign wd_o    = done_o ? wd_reg : wd_out_reg;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= IDLE;
         op_reg     <= '0;
         wd_reg     <= '0;
         opnd_reg   <= '0;
         acc_reg    <= '0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         count_reg  <= '0;
         wdata_reg  <= '0;
         wd_out_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg    <= op_i;
            wd_reg    <= wd_i;
            count_reg <= CW'(N);
            if (div_zero) begin
               // quotient all ones, remainder = raw dividend, no sign fix
               opnd_reg  <= '0;
               acc_reg   <= {reg1_i, {XLEN{1'b1}}};
               neg_q_reg <= 1'b0;
               neg_r_reg <= 1'b0;
            end else if (div_ovf) begin
               // quotient = raw dividend, remainder 0, no sign fix
               opnd_reg  <= '0;
               acc_reg   <= {{XLEN{1'b0}}, reg1_i};
               neg_q_reg <= 1'b0;
               neg_r_reg <= 1'b0;
            end else if (op_i[2]) begin
               opnd_reg  <= b_mag;
               acc_reg   <= {{XLEN{1'b0}}, a_mag};
               neg_q_reg <= neg_a ^ neg_b;
               neg_r_reg <= neg_a;
            end else begin
               opnd_reg  <= a_mag;
               acc_reg   <= {{XLEN{1'b0}}, b_mag};
               neg_q_reg <= neg_a ^ neg_b;
               neg_r_reg <= 1'b0;
            end
         end
         if ((state_reg == CALC) && !flush_i) begin
            acc_reg   <= acc_step;
            count_reg <= count_reg - 1'b1;
         end
         if (done_o) begin
            wdata_reg  <= result;
            wd_out_reg <= wd_reg;
         end
      end
   end

endmodule
